// File: rtl/pb_cond_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM encoding,
// default timing constants and the counter-width helper.
package pb_cond_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } pb_state_t;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
// cand is combinational and marks the cycle whose edge enters HELD or repeats.
module pb_debounce_ch
  import pb_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic cand,
  output logic held
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync;
  logic             synced;
  pb_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;
  logic             rep_phase;  // 0: waiting for first repeat, 1: periodic
  logic             enter_held;
  logic             repeat_hit;

  // NOTE: every register here uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], raw};
  end

  assign synced = sync[1];

  // NOTE: outputs of always_comb get a default first so no latch is inferred.
  always_comb begin
    enter_held = 1'b0;
    repeat_hit = 1'b0;
    if (state == DEB_PRESS && synced && cnt == DEB_LAST)
      enter_held = 1'b1;
    if (REPEAT_EN != 0 && state == HELD && synced &&
        rcnt == (rep_phase ? PER_LAST : DLY_LAST))
      repeat_hit = 1'b1;
  end

  assign cand = enter_held | repeat_hit;
  assign held = (state == HELD) || (state == DEB_RELEASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (synced) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!synced) begin
            state <= IDLE;
          end else if (enter_held) begin
            state     <= HELD;
            rcnt      <= '0;
            rep_phase <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!synced) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (repeat_hit) begin
            rcnt      <= '0;
            rep_phase <= 1'b1;
          end else if (REPEAT_EN != 0) begin
            rcnt <= rcnt + 1'b1;
          end
        end
        DEB_RELEASE: begin
          // Repeat count is frozen here so a release glitch resumes, not restarts.
          if (synced)               state <= HELD;
          else if (cnt == DEB_LAST) state <= IDLE;
          else                      cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pb_conditioner.sv
// Increment/decrement button conditioner: two debounce channels, with
// simultaneous strobes cancelled and the result registered.
module pb_conditioner
  import pb_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic pb_inc,
  output logic pb_dec,
  output logic inc_held,
  output logic dec_held
);

  logic cand_inc;
  logic cand_dec;

  pb_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_inc (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_inc_raw),
    .cand (cand_inc),
    .held (inc_held)
  );

  pb_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_dec_raw),
    .cand (cand_dec),
    .held (dec_held)
  );

  // Coinciding strobes cancel; the self-mask keeps a strobe to one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_inc <= 1'b0;
      pb_dec <= 1'b0;
    end else begin
      pb_inc <= cand_inc & ~cand_dec & ~pb_inc;
      pb_dec <= cand_dec & ~cand_inc & ~pb_dec;
    end
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: a repeat-enabled and a repeat-disabled instance
// share stimulus and are compared every cycle against a run-length model.
module tb_pb_conditioner;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_inc_raw = 1'b0;
  logic       btn_dec_raw = 1'b0;
  logic [1:0] pb_inc_w, pb_dec_w, inc_held_w, dec_held_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pb_conditioner #(.DEBOUNCE_CYCLES(DC), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_rep (
    .clk(clk), .rst(rst), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .pb_inc(pb_inc_w[0]), .pb_dec(pb_dec_w[0]), .inc_held(inc_held_w[0]), .dec_held(dec_held_w[0]));

  pb_conditioner #(.DEBOUNCE_CYCLES(DC), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_norep (
    .clk(clk), .rst(rst), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .pb_inc(pb_inc_w[1]), .pb_dec(pb_dec_w[1]), .inc_held(inc_held_w[1]), .dec_held(dec_held_w[1]));

  // Model: the debounced level flips once the synchronized input has disagreed
  // with it for DC+1 consecutive samples; k counts steady held samples.
  typedef struct {
    bit s1, s2;
    bit held;
    int run;
    int k;
    bit fire;
  } ch_model_t;

  ch_model_t mdl [2][2];
  bit        exp_inc [2];
  bit        exp_dec [2];
  bit        rep_en  [2] = '{1'b1, 1'b0};

  function automatic ch_model_t ch_next(ch_model_t m, bit raw, bit ren);
    ch_model_t n = m;
    bit s = m.s2;
    n.s2   = m.s1;
    n.s1   = raw;
    n.fire = 1'b0;
    if (!m.held) begin
      if (s) begin
        n.run = m.run + 1;
        if (n.run == DC + 1) begin
          n.held = 1'b1; n.run = 0; n.k = 0; n.fire = 1'b1;
        end
      end else begin
        n.run = 0;
      end
    end else if (s) begin
      if (m.run == 0) begin
        n.k = m.k + 1;
        if (ren && (n.k == RD || (n.k > RD && (n.k - RD) % RP == 0))) n.fire = 1'b1;
      end
      n.run = 0;
    end else begin
      n.run = m.run + 1;
      if (n.run == DC + 1) begin
        n.held = 1'b0; n.run = 0;
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) mdl[i][c] = '{default: 0};
      exp_inc[i] = 1'b0;
      exp_dec[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    ch_model_t n0, n1;
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        n0 = ch_next(mdl[i][0], btn_inc_raw, rep_en[i]);
        n1 = ch_next(mdl[i][1], btn_dec_raw, rep_en[i]);
        exp_inc[i] = n0.fire && !n1.fire && !exp_inc[i];
        exp_dec[i] = n1.fire && !n0.fire && !exp_dec[i];
        mdl[i][0] = n0;
        mdl[i][1] = n1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pb_inc[%0d]", i),   32'(pb_inc_w[i]),   32'(exp_inc[i]));
      check($sformatf("pb_dec[%0d]", i),   32'(pb_dec_w[i]),   32'(exp_dec[i]));
      check($sformatf("inc_held[%0d]", i), 32'(inc_held_w[i]), 32'(mdl[i][0].held));
      check($sformatf("dec_held[%0d]", i), 32'(dec_held_w[i]), 32'(mdl[i][1].held));
    end
  endtask

  // Returns 1 ns after the edge; inputs are changed only from that point.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  task automatic settle();
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    repeat (2 * DC + 8) tick();
  endtask

  initial begin
    int q[$];
    int n_other, n_held;
    int exp_rep [7] = '{6, 16, 21, 26, 31, 36, 41};
    int rem_inc, rem_dec;

    model_reset();
    #2;
    compare_all();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();

    // Clean press on the non-repeating instance: one strobe, 6 edges in.
    btn_inc_raw = 1'b1;
    n_other = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 30) btn_inc_raw = 1'b0;
      tick();
      if (pb_inc_w[1]) q.push_back(i);
      if (pb_dec_w[1] || pb_dec_w[0]) n_other++;
    end
    check("clean_count", q.size(), 1);
    check("clean_cycle", (q.size() > 0) ? q[0] : -1, 6);
    check("clean_no_dec", n_other, 0);
    settle();

    // Bounce: 2-cycle toggling never qualifies.
    q.delete(); n_held = 0;
    for (int i = 0; i < 30; i++) begin
      btn_inc_raw = (i < 20) && ((i / 2) % 2 == 0);
      tick();
      if (pb_inc_w[0] || pb_inc_w[1]) q.push_back(i);
      if (inc_held_w[0] || inc_held_w[1]) n_held++;
    end
    check("bounce_pulses", q.size(), 0);
    check("bounce_held", n_held, 0);
    settle();

    // Auto-repeat on decrement held for 40 cycles.
    q.delete();
    btn_dec_raw = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (i == 40) btn_dec_raw = 1'b0;
      tick();
      if (pb_dec_w[0]) q.push_back(i);
    end
    check("repeat_count", q.size(), 7);
    for (int j = 0; j < 7; j++)
      check($sformatf("repeat_at_%0d", j), (j < q.size()) ? q[j] : -1, exp_rep[j]);
    settle();

    // Simultaneous press: strobes cancel on the HELD-entry edge.
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) begin
        check("simul_pb_inc", 32'(pb_inc_w[0]), 0);
        check("simul_pb_dec", 32'(pb_dec_w[0]), 0);
        check("simul_inc_held", 32'(inc_held_w[0]), 1);
        check("simul_dec_held", 32'(dec_held_w[0]), 1);
      end
    end
    settle();

    // Reset in mid-debounce with the button still pressed.
    btn_inc_raw = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    do_reset(3);
    q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pb_inc_w[1]) q.push_back(i);
    end
    check("rst_count", q.size(), 1);
    check("rst_cycle", (q.size() > 0) ? q[0] : -1, 6);
    settle();

    // Randomized: mixed bounces and long holds on both buttons, rare resets.
    rem_inc = 0;
    rem_dec = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rem_inc == 0) begin
        btn_inc_raw = 1'($urandom_range(0, 1));
        rem_inc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 45);
      end
      if (rem_dec == 0) begin
        btn_dec_raw = 1'($urandom_range(0, 1));
        rem_dec = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 45);
      end
      rem_inc--;
      rem_dec--;
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
